// File: rtl/lsu.sv
// Load/store unit: bridges the core data port to a req/ack memory bus.
// Adds sub-word accesses, core stall, fault reporting and a bus watchdog.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessFault,
  output logic        BusError,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [15:0] TMO = TIMEOUT[15:0];

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        access;
  logic        illegal;
  logic        misal;
  logic        legal;
  logic        go;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  lb_byte;
  logic [15:0] lh_half;
  logic [31:0] ldata;

  assign access = MemRead | MemWrite;

  always_comb begin
    illegal = 1'b0;
    if (MemRead && MemWrite)
      illegal = 1'b1;
    else if (MemRead)
      illegal = funct3 inside {3'b011, 3'b110, 3'b111};
    else if (MemWrite)
      illegal = funct3[2] | (funct3[1:0] == 2'b11);
  end

  always_comb begin
    misal = 1'b0;
    if (funct3[1:0] == 2'b01)
      misal = Adr[0];
    else if (funct3[1:0] == 2'b10)
      misal = Adr[1:0] != 2'b00;
  end

  assign legal = access & ~illegal & ~misal;
  assign go    = (state == IDLE) & legal;

  // Stall never looks at mem_ack, so the core path stays ack-independent.
  assign Stall       = ~reset & (go | (state == REQ));
  assign AccessFault = ~reset & (state == IDLE) & access & ~legal;

  always_comb begin
    be    = 4'b0001 << Adr[1:0];
    wdata = {4{WriteData[7:0]}};
    unique case (1'b1)
      funct3[1:0] == 2'b10: begin
        be    = 4'b1111;
        wdata = WriteData;
      end
      funct3[1:0] == 2'b01: begin
        be    = 4'b0011 << Adr[1:0];
        wdata = {2{WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  assign lb_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign lh_half = mem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ldata = mem_rdata;
    unique case (1'b1)
      f3_q == 3'b000: ldata = {{24{lb_byte[7]}}, lb_byte};
      f3_q == 3'b100: ldata = {24'b0, lb_byte};
      f3_q == 3'b001: ldata = {{16{lh_half[15]}}, lh_half};
      f3_q == 3'b101: ldata = {16'b0, lh_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      ReadData  <= '0;
      BusError  <= 1'b0;
    end else begin
      BusError <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state     <= REQ;
            cnt       <= '0;
            f3_q      <= funct3;
            off_q     <= Adr[1:0];
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_be    <= be;
            mem_adr   <= {Adr[31:2], 2'b00};
            mem_wdata <= wdata;
          end
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
            if (!mem_we)
              ReadData <= ldata;
          end else if (cnt == TMO) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_be   <= '0;
            BusError <= 1'b1;
            if (!mem_we)
              ReadData <= '0;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the single-cycle RISC-V core's data-memory port and a variable-latency data memory. It turns the core's one-cycle MemWrite/ALUResult/WriteData access into a req/ack bus transaction, adds byte and halfword loads and stores (lb/lh/lw/lbu/lhu, sb/sh/sw), and stalls the core until each access completes. It also reports misaligned or illegal accesses and bus timeouts.

## Interface
- TIMEOUT, 255: maximum cycles in REQ without mem_ack before the access is abandoned (1..65535).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- MemRead  in  1  core requests a load this instruction
- MemWrite  in  1  core requests a store this instruction
- funct3  in  3  access size/sign, taken from Instr[14:12]
- Adr  in  32  byte address (ALUResult)
- WriteData  in  32  store data (rs2)
- ReadData  out  32  extended load result, registered
- Stall  out  1  core must hold PC and suppress register writeback
- AccessFault  out  1  misaligned or illegal access, combinational
- BusError  out  1  one-cycle pulse on timeout
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write, registered
- mem_be  out  4  byte enables, bit i = byte lane i, registered
- mem_adr  out  32  word address {Adr[31:2],2'b00}, registered
- mem_wdata  out  32  lane-replicated store data, registered
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  completion, one cycle, honoured only in REQ

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- An access occurs when MemRead or MemWrite is 1.
- Legality is decided combinationally in IDLE:
  - MemRead and MemWrite both set: illegal.
  - Load funct3 011, 110 or 111: illegal.
  - Store funct3 not in {000, 001, 010}: illegal.
  - Halfword with Adr[0]=1: misaligned.
  - Word with Adr[1:0]!=0: misaligned.
- Illegal or misaligned access in IDLE:
  - AccessFault=1 and Stall=0.
  - No bus request is issued, ReadData is unchanged and the FSM stays in IDLE.
- Legal access in IDLE:
  - Stall=1.
  - On the next edge the FSM goes to REQ and loads the bus registers.
  - mem_be: byte 4'b0001<<Adr[1:0]; half 4'b0011<<Adr[1:0]; word 4'b1111.
  - mem_wdata: sb {4{WriteData[7:0]}}; sh {2{WriteData[15:0]}}; sw WriteData.
  - mem_we=MemWrite.
- REQ:
  - Stall=1 and mem_req=1; all mem_* outputs are held stable.
  - The watchdog counter increments every cycle.
  - mem_ack=1: on the next edge go to DONE, drop mem_req, and latch ReadData for loads.
  - For stores ReadData is unchanged.
- Load extraction from mem_rdata at lane Adr[1:0]:
  - lb sign-extends bits [8*k+7:8*k]; lbu zero-extends the same bits.
  - lh/lhu select lane pair Adr[1]; lh sign-extends, lhu zero-extends.
  - lw passes the word through.
- Timeout: counter reaches TIMEOUT with no ack.
  - On the next edge go to DONE, drop mem_req and pulse BusError for that DONE cycle.
  - For a load, ReadData=0.
- DONE:
  - Stall=0, so the core retires the instruction on this edge.
  - Unconditionally return to IDLE; the access inputs are not re-sampled in DONE.
- mem_ack outside REQ is ignored.
- The counter clears on entry to REQ.
- Outputs when the FSM is idle: mem_be=0, mem_req=0, mem_we=0.

## Timing
- Reset, effective at the rising edge:
  - State goes to IDLE and the counter to 0.
  - mem_req, mem_we, mem_be, mem_adr, mem_wdata, ReadData and BusError all go to 0.
  - Stall and AccessFault are 0 during reset.
- Reset in REQ: mem_req drops at that edge, and any transaction in flight is abandoned.
- Minimum access time is 3 cycles:
  - cycle 0: IDLE, access seen, Stall=1.
  - cycle 1: REQ, mem_req=1, mem_ack=1.
  - cycle 2: DONE, ReadData valid, Stall=0.
- Each extra wait cycle before mem_ack adds one cycle.
- Timeout path: DONE occurs TIMEOUT+1 cycles after REQ entry.
- Back-to-back accesses: the next access is seen in the IDLE cycle after DONE, giving a 3-cycle minimum per access.
- Stall is combinational from state and inputs (IDLE&legal | REQ); it must not depend on mem_ack.

## Test plan
- sw 0x11223344 to 0x64, ack after 1 cycle -> mem_req high exactly 1 cycle, mem_be=1111, mem_adr=0x64, Stall high for 2 cycles.
- sb 0x000000A5 to 0x67, then lb and lbu at 0x67 with mem_rdata=0xA5xxxxxx -> mem_be=1000, mem_wdata=0xA5A5A5A5, lb ReadData=0xFFFFFFA5, lbu ReadData=0x000000A5.
- lh at 0x62 with mem_rdata=0x8001xxxx, ack after 4 wait cycles -> ReadData=0xFFFF8001 in DONE, Stall high for 6 cycles.
- lw at 0x66 -> AccessFault=1 the same cycle, Stall=0, no mem_req. MemRead and MemWrite both set -> AccessFault=1.
- lw with TIMEOUT=4 and no ack -> mem_req high 5 cycles, BusError pulses 1 cycle, ReadData=0, FSM returns to IDLE.
- reset asserted during REQ -> mem_req=0 after that edge, ReadData=0. A late mem_ack after reset causes no state change.
